// File: rtl/serial_sub_ctrl_if.sv
// Start/done handshake, operands and results of the bit-serial subtractor.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done, ovf
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH clocks with one full-subtractor.
// Define SERIAL_SUB_SIGNED_EN to register two's-complement overflow on ovf (tied to 0 otherwise).
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  serial_sub_ctrl_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, diff_q;
  logic             br_q, bout_q, busy_q, done_q;
  logic [CntW-1:0]  cnt_q;

  logic x, y, d, bo, last, accept;

  always_comb begin
    x      = a_sh_q[0];
    y      = b_sh_q[0];
    d      = x ^ y ^ br_q;
    bo     = (~x & y) | (~(x ^ y) & br_q);
    last   = (cnt_q == LastCnt);
    accept = (state_q != StRun) && bus.start;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            br_q    <= bus.bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          res_sh_q <= {d, res_sh_q[WIDTH-1:1]};
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          br_q     <= bo;
          if (last) begin
            diff_q  <= {d, res_sh_q[WIDTH-1:1]};
            bout_q  <= bo;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SERIAL_SUB_SIGNED_EN
  // Operand MSBs are shifted out early, so keep copies for the overflow test.
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
    end else if (state_q == StRun && last) begin
      // d is the result MSB on the final edge
      ovf_q <= (a_msb_q != b_msb_q) && (d != a_msb_q);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8) with a cycle-level reference model.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;
`ifdef SERIAL_SUB_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: arithmetic result plus a countdown of the WIDTH-clock latency.
  logic [W-1:0] m_diff, r_diff;
  logic         m_bout, m_ovf, m_busy, m_done, r_bout, r_ovf;
  int           m_left;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_diff <= '0; m_bout <= 0; m_ovf <= 0; m_busy <= 0; m_done <= 0; m_left <= 0;
      r_diff <= '0; r_bout <= 0; r_ovf <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_diff <= r_diff;
          m_bout <= r_bout;
          m_ovf  <= r_ovf;
        end
        m_left <= m_left - 1;
      end else if (bus.start) begin
        int r;
        r = int'(bus.a) - int'(bus.b) - int'(bus.bin);
        r_diff <= W'(r & 'hFF);
        r_bout <= (r < 0);
        r_ovf  <= SignedEn && (bus.a[W-1] != bus.b[W-1]) && (r[W-1] != bus.a[W-1]);
        m_busy <= 1'b1;
        m_left <= W;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("diff", bus.diff, m_diff);
      check("bout", bus.bout, m_bout);
      check("ovf", bus.ovf, m_ovf);
      check("busy_done_excl", bus.busy & bus.done, 0);
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(posedge clock); #1;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int busy_cnt);
    seen = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) begin seen = 1; break; end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb, input logic eo);
    bit seen;
    int bc;
    issue(a, b, bin);
    wait_done(seen, bc);
    check({name, "_done_seen"}, seen, 1);
    check({name, "_busy_cycles"}, bc, W);
    check({name, "_diff"}, bus.diff, ed);
    check({name, "_bout"}, bus.bout, eb);
    check({name, "_ovf"}, bus.ovf, eo);
  endtask

  initial begin
    bit seen;
    int bc;
    int n;
    int t[3];
    reset_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (2) @(posedge clock); #1;
    chk_en = 1'b1;
    check("rst_diff", bus.diff, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    reset_n = 1'b1;

    run_op("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    // Abort at the 4th RUN edge; outputs must clear immediately.
    issue(8'h10, 8'h01, 1'b0);
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("abort_diff", bus.diff, 0);
    check("abort_bout", bus.bout, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.done) n++;
    end
    check("abort_no_done", n, 0);

    run_op("underflow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("bin_zero", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("ff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

    // Start pulse in the 3rd RUN cycle with other operands is ignored.
    issue(8'h05, 8'h03, 1'b0);
    repeat (2) @(posedge clock); #1;
    bus.start = 1'b1; bus.a = 8'h77; bus.b = 8'h11; bus.bin = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    wait_done(seen, bc);
    check("ign_done_seen", seen, 1);
    check("ign_diff", bus.diff, 8'h02);
    check("ign_bout", bus.bout, 0);
    repeat (3) @(posedge clock);

    // Start held high: one result every W+1 clocks.
    #1;
    bus.start = 1'b1; bus.a = 8'h09; bus.b = 8'h04; bus.bin = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clock);
      if (bus.done) begin t[n] = cyc; n++; end
    end
    check("hold_count", n, 3);
    check("hold_gap0", t[1] - t[0], W + 1);
    check("hold_gap1", t[2] - t[1], W + 1);
    check("hold_diff", bus.diff, 8'h05);
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (12) @(posedge clock);

    run_op("signed_ovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, SignedEn);
    run_op("signed_ok", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

- Bit-serial N-bit subtractor controller: computes `a - b - bin` LSB-first, one bit per clock, with a single internal full-subtractor cell.
- Owns the operand shift registers, borrow flip-flop, bit counter and start/done handshake around that cell.
- Sits between a requesting master and the subtraction datapath; trades latency for area in the lab's arithmetic designs.

## Interface
Parameters:
- `WIDTH`, default 8, operand and result width in bits (legal range 2..32).

Ports (clock and reset first):
- `clock`  input  1  single rising-edge clock for all state.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled on a rising edge while in IDLE or DONE.
- `a`  input  WIDTH  minuend; captured on the accepted `start`.
- `b`  input  WIDTH  subtrahend; captured on the accepted `start`.
- `bin`  input  1  initial borrow-in; captured on the accepted `start`.
- `diff`  output  WIDTH  registered result `(a - b - bin) mod 2^WIDTH`.
- `bout`  output  1  registered final borrow-out: 1 when `a < b + bin` (unsigned).
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse when `diff`/`bout` are updated.
- `ovf`  output  1  signed overflow flag; see Configuration.

## Operation
- Bit cell, combinational: `d = x ^ y ^ br`; `bo = (~x & y) | (~(x ^ y) & br)`. Here `x` and `y` are the LSBs of the a/b shift registers and `br` is the borrow flip-flop.
- FSM states: IDLE, RUN, DONE; reset state is IDLE.
- IDLE or DONE with `start`=1:
  - load `a` and `b` into the shift registers and `bin` into the borrow flop;
  - clear the counter; go to RUN.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- Each RUN edge:
  - shift `d` into the MSB of the result shift register;
  - shift the a/b registers right by one;
  - borrow flop <= `bo`; counter increments.
- RUN edge with counter = WIDTH-1:
  - `diff` <= final result word; `bout` <= final `bo`; `ovf` updated;
  - go to DONE.
- `start` is ignored while in RUN; the `a`/`b`/`bin` pins are don't-care outside an accepted `start`.
- `diff`, `bout` and `ovf` hold their values until the next completion; they are not cleared by `start`.
- Counter width is `$clog2(WIDTH)`; it never wraps, because RUN exits at WIDTH-1.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `diff`=0, `bout`=0, `ovf`=0, `busy`=0, `done`=0; shift registers, borrow flop and counter are cleared.
- Reset asserted mid-RUN aborts the operation; no `done` is produced.
- Edge E0 accepts `start`.
- `busy`=1 from after E0 through E_WIDTH.
- `diff`/`bout` are valid and `done`=1 for exactly one cycle, after edge E_WIDTH.
- Latency: WIDTH clocks from the accepting edge to `done`.
- Back-to-back: a `start` held high through DONE is accepted at E_WIDTH+1. Throughput is therefore one result per WIDTH+1 clocks, and `done` never merges across operations.
- `busy` and `done` are never high together.

## Configuration
- `SERIAL_SUB_SIGNED_EN` defined:
  - `ovf` is registered at completion as two's-complement overflow: `ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`, using the captured operands.
  - The `bin` term is included in `diff`.
- `SERIAL_SUB_SIGNED_EN` undefined: the capture registers for the operand MSBs are omitted, and `ovf` is tied to 0.
- The `ovf` port exists in both builds.

## Test plan
All cases use WIDTH=8.
- Reset mid-RUN: `start` with a=0x10, b=0x01; pull `reset_n` low for 1 cycle at the 4th RUN edge. Required: all outputs 0 immediately, no `done`, state IDLE; a fresh `start` afterwards runs normally.
- Basic: a=0x05, b=0x03, bin=0 -> after 8 clocks `done`=1 for 1 cycle, `diff`=0x02, `bout`=0, `busy` high for exactly 8 cycles.
- Underflow: a=0x03, b=0x05, bin=0 -> `diff`=0xFE, `bout`=1.
- Borrow-in: a=0x00, b=0x00, bin=1 -> `diff`=0xFF, `bout`=1. Then a=0xFF, b=0xFF, bin=0 -> `diff`=0x00, `bout`=0.
- Handshake:
  - pulse `start` at the 3rd RUN cycle with different operands -> ignored, and the first result is unchanged;
  - hold `start`=1 continuously -> a `done` pulse every 9 clocks.
- Signed (macro defined): a=0x80, b=0x01 -> `diff`=0x7F, `bout`=0, `ovf`=1. Then a=0x05, b=0x03 -> `ovf`=0. With the macro undefined, `ovf` stays 0 for the first case.
